// File: rtl/sump_pkg.sv
// Shared definitions for the SUMP command front end: opcode values, the
// decoder state type and the long-command payload length.
package sump_pkg;

  // Short (single-byte) commands
  localparam logic [7:0] OP_RESET = 8'h00;
  localparam logic [7:0] OP_ARM   = 8'h01;
  localparam logic [7:0] OP_ID    = 8'h02;
  localparam logic [7:0] OP_XON   = 8'h11;
  localparam logic [7:0] OP_XOFF  = 8'h13;

  // Long (opcode + 4 payload bytes) commands
  localparam logic [7:0] OP_DIV   = 8'h80;
  localparam logic [7:0] OP_CNT   = 8'h81;
  localparam logic [7:0] OP_FLAGS = 8'h82;
  localparam logic [7:0] OP_TMASK = 8'hC0;
  localparam logic [7:0] OP_TVAL  = 8'hC1;
  localparam logic [7:0] OP_TCFG  = 8'hC2;

  localparam int unsigned PAYLOAD_LEN = 4;
  localparam logic [1:0]  LAST_INDEX  = 2'(PAYLOAD_LEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    PAYLOAD,
    COMMIT
  } state_t;

  // True for long opcodes that target a configuration register.
  function automatic logic is_cfg_opcode(input logic [7:0] op);
    return op inside {OP_DIV, OP_CNT, OP_FLAGS, OP_TMASK, OP_TVAL, OP_TCFG};
  endfunction

endpackage

// File: rtl/sump_byte_timeout.sv
// Idle-cycle counter guarding long-command payload assembly.
// Ports:
//   system_clock  core clock
//   ext_reset_n   asynchronous active-low reset
//   clear         reload the counter to zero this cycle
//   expired       counter has reached TIMEOUT_CYCLES-1
module sump_byte_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 200_000
) (
  input  logic system_clock,
  input  logic ext_reset_n,
  input  logic clear,
  output logic expired
);

  localparam int unsigned CNT_WIDTH = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_WIDTH-1:0] LAST_COUNT = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [CNT_WIDTH-1:0] count_q;

  always_ff @(posedge system_clock or negedge ext_reset_n) begin
    if (!ext_reset_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (count_q != LAST_COUNT) begin
      // Saturate so a stalled owner cannot wrap back to a fresh window.
      count_q <= count_q + 1'b1;
    end
  end

  assign expired = (count_q == LAST_COUNT);

endmodule

// File: rtl/sump_cmd_decoder.sv
// SUMP command decoder: frames UART bytes into short and long commands, holds
// the capture configuration registers and issues single-cycle control pulses.
// Ports:
//   system_clock, ext_reset_n      clock, asynchronous active-low reset
//   rx_data, rx_valid              received byte and its one-cycle strobe
//   capture_busy                   sequencer armed/capturing; blocks writes and arm
//   divider .. flags               configuration registers
//   core_reset, arm, id_req,
//   xon, xoff                      one-cycle pulses, the cycle after the short command
//   cfg_update                     a configuration register is written this cycle
//   cmd_error                      unknown long opcode, rejected write or payload timeout
module sump_cmd_decoder
  import sump_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 200_000,
  parameter logic [23:0] DIV_DEFAULT    = 24'd0,
  parameter logic [15:0] COUNT_DEFAULT  = 16'd0
) (
  input  logic        system_clock,
  input  logic        ext_reset_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        capture_busy,
  output logic [23:0] divider,
  output logic [15:0] read_count,
  output logic [15:0] delay_count,
  output logic [31:0] trig_mask,
  output logic [31:0] trig_value,
  output logic [31:0] trig_config,
  output logic [31:0] flags,
  output logic        core_reset,
  output logic        arm,
  output logic        id_req,
  output logic        xon,
  output logic        xoff,
  output logic        cfg_update,
  output logic        cmd_error
);

  state_t      state_q;
  logic [7:0]  opcode_q;
  logic [1:0]  index_q;
  logic [31:0] payload_q;

  logic [23:0] divider_q;
  logic [15:0] read_count_q, delay_count_q;
  logic [31:0] trig_mask_q, trig_value_q, trig_config_q, flags_q;
  logic        core_reset_q, arm_q, id_req_q, xon_q, xoff_q;

  logic byte_is_cmd, short_cmd, long_cmd, in_commit, commit_write;
  logic timeout_hit, timer_clear, timer_expired;
  logic wr_div, wr_cnt, wr_flags, wr_tmask, wr_tval, wr_tcfg;

  always_comb begin
    // Outside PAYLOAD a byte starts a new command; this includes COMMIT so no byte is lost.
    byte_is_cmd  = rx_valid && (state_q != PAYLOAD);
    short_cmd    = byte_is_cmd && !rx_data[7];
    long_cmd     = byte_is_cmd && rx_data[7];
    in_commit    = (state_q == COMMIT);
    commit_write = in_commit && is_cfg_opcode(opcode_q) && !capture_busy;
    timeout_hit  = (state_q == PAYLOAD) && !rx_valid && timer_expired;
    timer_clear  = rx_valid || (state_q != PAYLOAD);
    wr_div       = commit_write && (opcode_q == OP_DIV);
    wr_cnt       = commit_write && (opcode_q == OP_CNT);
    wr_flags     = commit_write && (opcode_q == OP_FLAGS);
    wr_tmask     = commit_write && (opcode_q == OP_TMASK);
    wr_tval      = commit_write && (opcode_q == OP_TVAL);
    wr_tcfg      = commit_write && (opcode_q == OP_TCFG);
  end

  sump_byte_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .system_clock(system_clock),
    .ext_reset_n (ext_reset_n),
    .clear       (timer_clear),
    .expired     (timer_expired)
  );

  always_ff @(posedge system_clock or negedge ext_reset_n) begin
    if (!ext_reset_n) begin
      state_q       <= IDLE;
      opcode_q      <= '0;
      index_q       <= '0;
      payload_q     <= '0;
      divider_q     <= DIV_DEFAULT;
      read_count_q  <= COUNT_DEFAULT;
      delay_count_q <= COUNT_DEFAULT;
      trig_mask_q   <= '0;
      trig_value_q  <= '0;
      trig_config_q <= '0;
      flags_q       <= '0;
      core_reset_q  <= 1'b0;
      arm_q         <= 1'b0;
      id_req_q      <= 1'b0;
      xon_q         <= 1'b0;
      xoff_q        <= 1'b0;
    end else begin
      core_reset_q <= 1'b0;
      arm_q        <= 1'b0;
      id_req_q     <= 1'b0;
      xon_q        <= 1'b0;
      xoff_q       <= 1'b0;

      if (short_cmd) begin
        case (rx_data)
          OP_RESET: core_reset_q <= 1'b1;
          OP_ARM:   arm_q        <= !capture_busy;
          OP_ID:    id_req_q     <= 1'b1;
          OP_XON:   xon_q        <= 1'b1;
          OP_XOFF:  xoff_q       <= 1'b1;
          default:  ;
        endcase
      end

      if (wr_div)   divider_q <= payload_q[23:0];
      if (wr_cnt) begin
        read_count_q  <= payload_q[15:0];
        delay_count_q <= payload_q[31:16];
      end
      if (wr_flags) flags_q       <= payload_q;
      if (wr_tmask) trig_mask_q   <= payload_q;
      if (wr_tval)  trig_value_q  <= payload_q;
      if (wr_tcfg)  trig_config_q <= payload_q;

      case (state_q)
        PAYLOAD: begin
          if (rx_valid) begin
            payload_q[{index_q, 3'b000} +: 8] <= rx_data;
            index_q <= index_q + 2'd1;
            if (index_q == LAST_INDEX) state_q <= COMMIT;
          end else if (timeout_hit) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          if (long_cmd) begin
            opcode_q <= rx_data;
            index_q  <= '0;
            state_q  <= PAYLOAD;
          end
        end
      endcase
    end
  end

  // The COMMIT write is visible in the COMMIT cycle itself, with busy sampled in that cycle.
  assign divider     = wr_div   ? payload_q[23:0]  : divider_q;
  assign read_count  = wr_cnt   ? payload_q[15:0]  : read_count_q;
  assign delay_count = wr_cnt   ? payload_q[31:16] : delay_count_q;
  assign flags       = wr_flags ? payload_q        : flags_q;
  assign trig_mask   = wr_tmask ? payload_q        : trig_mask_q;
  assign trig_value  = wr_tval  ? payload_q        : trig_value_q;
  assign trig_config = wr_tcfg  ? payload_q        : trig_config_q;

  assign core_reset = core_reset_q;
  assign arm        = arm_q;
  assign id_req     = id_req_q;
  assign xon        = xon_q;
  assign xoff       = xoff_q;
  assign cfg_update = commit_write;
  assign cmd_error  = (in_commit && !commit_write) || timeout_hit;

endmodule

// File: tb/tb_sump_cmd_decoder.sv
module tb_sump_cmd_decoder;

  localparam int unsigned T       = 64;
  localparam logic [23:0] DIV_DEF = 24'h00ABCD;
  localparam logic [15:0] CNT_DEF = 16'h0042;

  // Event bits: {core_reset, arm, id_req, xon, xoff, cfg_update, cmd_error}
  localparam logic [6:0] EV_RST  = 7'h40;
  localparam logic [6:0] EV_ARM  = 7'h20;
  localparam logic [6:0] EV_ID   = 7'h10;
  localparam logic [6:0] EV_XON  = 7'h08;
  localparam logic [6:0] EV_XOFF = 7'h04;
  localparam logic [6:0] EV_CFG  = 7'h02;
  localparam logic [6:0] EV_ERR  = 7'h01;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        busy = 1'b0;
  logic [23:0] divider;
  logic [15:0] read_count, delay_count;
  logic [31:0] trig_mask, trig_value, trig_config, flags;
  logic        core_reset, arm, id_req, xon, xoff, cfg_update, cmd_error;

  always #5 clk = ~clk;

  sump_cmd_decoder #(
    .TIMEOUT_CYCLES(T),
    .DIV_DEFAULT   (DIV_DEF),
    .COUNT_DEFAULT (CNT_DEF)
  ) dut (
    .system_clock(clk),
    .ext_reset_n (rst_n),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .capture_busy(busy),
    .divider     (divider),
    .read_count  (read_count),
    .delay_count (delay_count),
    .trig_mask   (trig_mask),
    .trig_value  (trig_value),
    .trig_config (trig_config),
    .flags       (flags),
    .core_reset  (core_reset),
    .arm         (arm),
    .id_req      (id_req),
    .xon         (xon),
    .xoff        (xoff),
    .cfg_update  (cfg_update),
    .cmd_error   (cmd_error)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned cyc;
    logic [6:0]  ev;
  } exp_t;
  exp_t sb_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a command is the list of bytes collected since the last
  // completed/abandoned command; five bytes starting with bit7 set form a write.
  logic [7:0]  pend[$];
  int unsigned last_cyc;
  logic [23:0] m_div;
  logic [15:0] m_rc, m_dc;
  logic [31:0] m_tmask, m_tval, m_tcfg, m_flags;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic void push_ev(input int unsigned c, input logic [6:0] ev);
    exp_t e;
    e.cyc = c;
    e.ev  = ev;
    sb_q.push_back(e);
  endfunction

  function automatic void model_reset();
    pend.delete();
    sb_q.delete();
    m_div   = DIV_DEF;
    m_rc    = CNT_DEF;
    m_dc    = CNT_DEF;
    m_tmask = '0;
    m_tval  = '0;
    m_tcfg  = '0;
    m_flags = '0;
  endfunction

  function automatic void model_commit(input int unsigned c);
    logic [31:0] p;
    logic        known;
    p = {pend[4], pend[3], pend[2], pend[1]};
    known = pend[0] inside {8'h80, 8'h81, 8'h82, 8'hC0, 8'hC1, 8'hC2};
    if (!known || busy) begin
      push_ev(c, EV_ERR);
    end else begin
      push_ev(c, EV_CFG);
      case (pend[0])
        8'h80: m_div = p[23:0];
        8'h81: begin m_rc = p[15:0]; m_dc = p[31:16]; end
        8'h82: m_flags = p;
        8'hC0: m_tmask = p;
        8'hC1: m_tval = p;
        default: m_tcfg = p;
      endcase
    end
    pend.delete();
  endfunction

  function automatic void model_byte(input logic [7:0] b, input int unsigned t);
    if (pend.size() == 0) begin
      if (!b[7]) begin
        case (b)
          8'h00: push_ev(t + 1, EV_RST);
          8'h01: if (!busy) push_ev(t + 1, EV_ARM);
          8'h02: push_ev(t + 1, EV_ID);
          8'h11: push_ev(t + 1, EV_XON);
          8'h13: push_ev(t + 1, EV_XOFF);
          default: ;
        endcase
      end else begin
        pend.push_back(b);
      end
    end else begin
      pend.push_back(b);
      if (pend.size() == 5) model_commit(t + 1);
    end
    last_cyc = t;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    model_byte(b, cyc);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  // Idle cycles start with the current one; a partial command times out T
  // cycles after its last byte if no byte arrives before then.
  task automatic idle(input int unsigned n);
    if (n > 0) begin
      if (pend.size() > 0 && last_cyc + T <= cyc + n - 1) begin
        push_ev(last_cyc + T, EV_ERR);
        pend.delete();
      end
      repeat (n) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic set_busy(input logic v);
    idle(1);
    busy = v;
  endtask

  task automatic check_regs(input string tag);
    check({tag, ".divider"}, 32'(divider), 32'(m_div));
    check({tag, ".read_count"}, 32'(read_count), 32'(m_rc));
    check({tag, ".delay_count"}, 32'(delay_count), 32'(m_dc));
    check({tag, ".trig_mask"}, trig_mask, m_tmask);
    check({tag, ".trig_value"}, trig_value, m_tval);
    check({tag, ".trig_config"}, trig_config, m_tcfg);
    check({tag, ".flags"}, flags, m_flags);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  logic [7:0]  b;
  logic [7:0]  op;
  int unsigned kind;
  logic [6:0]  obs_v, exp_v;

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    fork
      forever begin
        @(negedge clk);
        if (rst_n) begin
          obs_v = {core_reset, arm, id_req, xon, xoff, cfg_update, cmd_error};
          exp_v = '0;
          while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
            n_checks++;
            n_fail++;
            $display("FAIL missed_event: expected %b at cycle %0d was not observed", sb_q[0].ev,
                     sb_q[0].cyc);
            void'(sb_q.pop_front());
          end
          while (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
            exp_v = exp_v | sb_q[0].ev;
            void'(sb_q.pop_front());
          end
          if (obs_v != 0 || exp_v != 0) check("pulses", 32'(obs_v), 32'(exp_v));
        end
      end
    join_none

    // Reset state
    check("reset.pulses", 32'({core_reset, arm, id_req, xon, xoff, cfg_update, cmd_error}), 0);
    check_regs("reset");

    // Divider write, visible in the commit cycle
    send_byte(8'h80); send_byte(8'h40); send_byte(8'h42); send_byte(8'h0F); send_byte(8'h00);
    check("div_commit", 32'(divider), 32'h000F_4240);
    idle(3);
    check_regs("div");

    // Counts, then arm while idle
    send_byte(8'h81); send_byte(8'hFF); send_byte(8'h03); send_byte(8'h0F); send_byte(8'h00);
    check("read_count_commit", 32'(read_count), 32'h0000_03FF);
    check("delay_count_commit", 32'(delay_count), 32'h0000_000F);
    idle(2);
    send_byte(8'h01);
    idle(3);

    // Busy: write rejected, arm ignored, reset honoured
    set_busy(1'b1);
    send_byte(8'hC0); send_byte(8'hFF); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    idle(2);
    check("busy_tmask", trig_mask, 32'h0);
    send_byte(8'h01);
    idle(2);
    send_byte(8'h00);
    idle(2);
    check_regs("busy");
    set_busy(1'b0);

    // Payload timeout
    send_byte(8'h80); send_byte(8'h11);
    idle(T);
    send_byte(8'h02);
    idle(2);
    check_regs("timeout");

    // Resync with zeros
    send_byte(8'h80); send_byte(8'hAA); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    check("resync_div", 32'(divider), 32'h0000_00AA);
    send_byte(8'h00); send_byte(8'h00);
    idle(3);

    // Unknown long opcode, unknown short opcode
    send_byte(8'h9F); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    idle(2);
    send_byte(8'h55);
    idle(2);
    check_regs("unknown");

    // Randomised traffic
    for (int i = 0; i < 250; i++) begin
      idle($urandom_range(0, 3));
      if (pend.size() == 0 && $urandom_range(0, 7) == 0) set_busy($urandom_range(0, 3) == 0);
      kind = $urandom_range(0, 9);
      if (kind < 4) begin
        case ($urandom_range(0, 5))
          0: b = 8'h00;
          1: b = 8'h01;
          2: b = 8'h02;
          3: b = 8'h11;
          4: b = 8'h13;
          default: b = 8'($urandom_range(0, 127));
        endcase
        send_byte(b);
      end else begin
        case ($urandom_range(0, 6))
          0: op = 8'h80;
          1: op = 8'h81;
          2: op = 8'h82;
          3: op = 8'hC0;
          4: op = 8'hC1;
          5: op = 8'hC2;
          default: op = 8'($urandom_range(128, 255));
        endcase
        send_byte(op);
        for (int j = 0; j < 4; j++) begin
          if ($urandom_range(0, 40) == 0) idle(T + $urandom_range(0, 3));
          else idle($urandom_range(0, 1));
          send_byte(8'($urandom));
        end
      end
      if (i % 25 == 24) begin
        idle(2);
        check_regs("random");
      end
    end
    busy = 1'b0;
    idle(T + 5);
    check_regs("random_end");
    check("scoreboard_drained", sb_q.size(), 0);

    // Asynchronous reset in the middle of a payload
    send_byte(8'h80); send_byte(8'h12);
    #2;
    rst_n = 1'b0;
    #1;
    check("async.divider", 32'(divider), 32'(DIV_DEF));
    check("async.read_count", 32'(read_count), 32'(CNT_DEF));
    check("async.delay_count", 32'(delay_count), 32'(CNT_DEF));
    check("async.trig", trig_mask | trig_value | trig_config | flags, 32'h0);
    check("async.pulses", 32'({core_reset, arm, id_req, xon, xoff, cfg_update, cmd_error}), 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_byte(8'h02);
    idle(3);
    check_regs("post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
